// File: rtl/pe_bus_responder.sv
// Purpose: round-robin bus arbiter and responder serving PE memory and shared register-file transactions.
// Latency: grant one edge after request; register op pulse 2 edges after grant, memory op pulse 1+MEM_LAT edges after grant.
// Backpressure: level request held by the PE; grant is held until the granted PE drops its request.
//
// Ports:
//   clk, reset (async, active-low)
//   bus_request[N_PE] in / grant[N_PE] out (one-hot, registered)
//   mem_addressBus, result_outBus, rs1OutBus, rs2OutBus, rdOutBus, reg_selectBus,
//   mem_readBus, mem_writeBus, rd_writeBus, read_enBus  : command from the granted PE
//   memData + mem_ackBus                 : memory read data / memory and rd-write completion pulse
//   AmuxBus, BmuxBus + data_ReadyBus     : register-read operands / completion pulse
module pe_bus_responder #(
    parameter int N_PE    = 4,
    parameter int MEM_AW  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PE-1:0]   bus_request,
    output logic [N_PE-1:0]   grant,
    input  logic [31:0]       mem_addressBus,
    input  logic [31:0]       result_outBus,
    input  logic [4:0]        rs1OutBus,
    input  logic [4:0]        rs2OutBus,
    input  logic [4:0]        rdOutBus,
    input  logic              reg_selectBus,
    input  logic              mem_readBus,
    input  logic              mem_writeBus,
    input  logic              rd_writeBus,
    input  logic              read_enBus,
    output logic [31:0]       memData,
    output logic              mem_ackBus,
    output logic [31:0]       AmuxBus,
    output logic [31:0]       BmuxBus,
    output logic              data_ReadyBus
);

    localparam int PW    = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [N_PE-1:0] GRANT_ONE = N_PE'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_MEM_WAIT,
        S_RESP,
        S_RELEASE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MWR,
        OP_MRD,
        OP_RDW,
        OP_RDEN
    } op_t;

    state_t              state_q, state_d;
    logic [N_PE-1:0]     grant_q, grant_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       gidx_q, gidx_d;
    logic [3:0]          cnt_q, cnt_d;
    op_t                 op_q, op_d;
    logic [MEM_AW-1:0]   widx_q, widx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [4:0]          rs1_q, rs1_d;
    logic [4:0]          rs2_q, rs2_d;
    logic [4:0]          rd_q, rd_d;
    logic                rsel_q, rsel_d;
    logic [31:0]         mem_data_q, mem_data_d;
    logic                mem_ack_q, mem_ack_d;
    logic [31:0]         amux_q, amux_d;
    logic [31:0]         bmux_q, bmux_d;
    logic                drdy_q, drdy_d;
    logic [31:0]         regs_q [32];
    logic [31:0]         regs_d [32];

    // Global data memory: not reset, written only from the RESP state.
    logic [31:0]         gmem [DEPTH];
    logic                mem_we;

    logic                pick_vld;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       cand;

    // Byte-offset and high address bits are deliberately dropped (word addressing, wrap modulo depth).
    logic                unused_addr;
    assign unused_addr = ^{mem_addressBus[31:MEM_AW+2], mem_addressBus[1:0]};

    // Round-robin pick: first requester at or after rr_ptr. Walking the candidates
    // from farthest to nearest lets the nearest one overwrite the others.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = N_PE - 1; k >= 0; k--) begin
            cand = PW'((32'(rr_ptr_q) + 32'(k)) % 32'(N_PE));
            if (bus_request[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        gidx_d     = gidx_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        rsel_d     = rsel_q;
        mem_data_d = mem_data_q;
        mem_ack_d  = 1'b0;
        amux_d     = amux_q;
        bmux_d     = bmux_q;
        drdy_d     = 1'b0;
        regs_d     = regs_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d = GRANT_ONE << pick_idx;
                    gidx_d  = pick_idx;
                    state_d = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                widx_d  = mem_addressBus[MEM_AW+1:2];
                wdata_d = result_outBus;
                rs1_d   = rs1OutBus;
                rs2_d   = rs2OutBus;
                rd_d    = rdOutBus;
                rsel_d  = reg_selectBus;
                if (mem_writeBus)      op_d = OP_MWR;
                else if (mem_readBus)  op_d = OP_MRD;
                else if (rd_writeBus)  op_d = OP_RDW;
                else if (read_enBus)   op_d = OP_RDEN;
                else                   op_d = OP_NONE;

                // The counter holds the wait cycles left before RESP; RESP itself
                // provides the last of the MEM_LAT cycles, so one fewer is loaded.
                if (mem_writeBus || mem_readBus) begin
                    cnt_d   = 4'(MEM_LAT - 1);
                    state_d = (MEM_LAT == 1) ? S_RESP : S_MEM_WAIT;
                end else if (rd_writeBus || read_enBus) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_RELEASE;
                end
            end

            S_MEM_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_RESP: begin
                // The access lands on the same edge that raises the pulse, so the
                // data outputs are valid for the whole pulse cycle.
                case (op_q)
                    OP_MWR: begin
                        mem_we    = 1'b1;
                        mem_ack_d = 1'b1;
                    end
                    OP_MRD: begin
                        mem_data_d = gmem[widx_q];
                        mem_ack_d  = 1'b1;
                    end
                    OP_RDW: begin
                        if (rd_q != 5'd0) begin
                            regs_d[rd_q] = wdata_q;
                        end
                        mem_ack_d = 1'b1;
                    end
                    OP_RDEN: begin
                        // regs_q[0] is cleared on reset and never written, so x0 reads 0.
                        amux_d = regs_q[rs1_q];
                        bmux_d = rsel_q ? regs_q[rs2_q] : wdata_q;
                        drdy_d = 1'b1;
                    end
                    default: ;
                endcase
                state_d = S_RELEASE;
            end

            S_RELEASE: begin
                if (!bus_request[gidx_q]) begin
                    grant_d  = '0;
                    rr_ptr_d = PW'((32'(gidx_q) + 32'd1) % 32'(N_PE));
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            gidx_q     <= '0;
            cnt_q      <= '0;
            op_q       <= OP_NONE;
            widx_q     <= '0;
            wdata_q    <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rsel_q     <= 1'b0;
            mem_data_q <= '0;
            mem_ack_q  <= 1'b0;
            amux_q     <= '0;
            bmux_q     <= '0;
            drdy_q     <= 1'b0;
            regs_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            gidx_q     <= gidx_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            rsel_q     <= rsel_d;
            mem_data_q <= mem_data_d;
            mem_ack_q  <= mem_ack_d;
            amux_q     <= amux_d;
            bmux_q     <= bmux_d;
            drdy_q     <= drdy_d;
            regs_q     <= regs_d;
        end
    end

    // mem_we derives from state_q, which reset forces to IDLE, so a write
    // pending when reset hits is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            gmem[widx_q] <= wdata_q;
        end
    end

    assign grant         = grant_q;
    assign memData       = mem_data_q;
    assign mem_ackBus    = mem_ack_q;
    assign AmuxBus       = amux_q;
    assign BmuxBus       = bmux_q;
    assign data_ReadyBus = drdy_q;

endmodule

// File: tb/tb_pe_bus_responder.sv
// Purpose: directed self-checking bench for pe_bus_responder (N_PE=4, MEM_AW=8, MEM_LAT=2).
// Latency: checks pulse edges at E2 (register ops) and E3 (memory ops) after the grant edge E0.
// Backpressure: each PE holds its request through the transaction and drops it after the pulse.
module tb_pe_bus_responder;

    localparam int N_PE    = 4;
    localparam int MEM_AW  = 8;
    localparam int MEM_LAT = 2;
    localparam int LAT_MEM = 1 + MEM_LAT;
    localparam int LAT_REG = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_PE-1:0]   bus_request;
    logic [N_PE-1:0]   grant;
    logic [31:0]       mem_addressBus;
    logic [31:0]       result_outBus;
    logic [4:0]        rs1OutBus;
    logic [4:0]        rs2OutBus;
    logic [4:0]        rdOutBus;
    logic              reg_selectBus;
    logic              mem_readBus;
    logic              mem_writeBus;
    logic              rd_writeBus;
    logic              read_enBus;
    logic [31:0]       memData;
    logic              mem_ackBus;
    logic [31:0]       AmuxBus;
    logic [31:0]       BmuxBus;
    logic              data_ReadyBus;

    int n_tests = 0;
    int n_fail  = 0;

    pe_bus_responder #(
        .N_PE    (N_PE),
        .MEM_AW  (MEM_AW),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_request    (bus_request),
        .grant          (grant),
        .mem_addressBus (mem_addressBus),
        .result_outBus  (result_outBus),
        .rs1OutBus      (rs1OutBus),
        .rs2OutBus      (rs2OutBus),
        .rdOutBus       (rdOutBus),
        .reg_selectBus  (reg_selectBus),
        .mem_readBus    (mem_readBus),
        .mem_writeBus   (mem_writeBus),
        .rd_writeBus    (rd_writeBus),
        .read_enBus     (read_enBus),
        .memData        (memData),
        .mem_ackBus     (mem_ackBus),
        .AmuxBus        (AmuxBus),
        .BmuxBus        (BmuxBus),
        .data_ReadyBus  (data_ReadyBus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        n_tests++;
        assert (obs !== bad) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h must differ from 0x%08h", tag, obs, bad);
        end
    endtask

    task automatic set_cmd(input logic mw, input logic mr, input logic rw, input logic re,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdi,
                           input logic sel);
        mem_writeBus   = mw;
        mem_readBus    = mr;
        rd_writeBus    = rw;
        read_enBus     = re;
        mem_addressBus = addr;
        result_outBus  = data;
        rs1OutBus      = r1;
        rs2OutBus      = r2;
        rdOutBus       = rdi;
        reg_selectBus  = sel;
    endtask

    // Called with the DUT idle and bus_request already raised for pe.
    // Edge E0 grants, edge E(lat) carries the pulse, PE then drops its request
    // and the grant must clear on the following edge.
    task automatic run_txn(input int pe, input int lat, input logic exp_ack,
                           input logic exp_rdy, input string tag);
        logic [N_PE-1:0] g;
        g     = '0;
        g[pe] = 1'b1;
        tick();
        check({tag, " grant"}, 32'(grant), 32'(g));
        repeat (lat - 1) tick();
        check({tag, " early"}, {30'd0, mem_ackBus, data_ReadyBus}, 32'd0);
        tick();
        check({tag, " ack"}, 32'(mem_ackBus), 32'(exp_ack));
        check({tag, " rdy"}, 32'(data_ReadyBus), 32'(exp_rdy));
        check({tag, " hold"}, 32'(grant), 32'(g));
        bus_request[pe] = 1'b0;
        tick();
        check({tag, " release"}, {26'd0, grant, mem_ackBus, data_ReadyBus}, 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        bus_request = '0;
        set_cmd(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) tick();
        check("reset grant", 32'(grant), 32'd0);
        check("reset ack", 32'(mem_ackBus), 32'd0);
        check("reset rdy", 32'(data_ReadyBus), 32'd0);
        check("reset memData", memData, 32'd0);
        check("reset Amux", AmuxBus, 32'd0);
        check("reset Bmux", BmuxBus, 32'd0);
        reset = 1'b1;
        tick();

        // Reset in the middle of the wait of a write to 0x10.
        set_cmd(1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0001;
        tick();
        check("rstmid grant", 32'(grant), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check("rstmid grant clr", 32'(grant), 32'd0);
        check("rstmid ack", 32'(mem_ackBus), 32'd0);
        bus_request = '0;
        tick();
        reset = 1'b1;
        tick();
        check("rstmid no pulse", {30'd0, mem_ackBus, data_ReadyBus}, 32'd0);
        set_cmd(0, 1, 0, 0, 32'h10, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0001;
        run_txn(0, LAT_MEM, 1'b1, 1'b0, "rd10");
        check_ne("rd10 dropped data", memData, 32'hDEADBEEF);

        // Memory write/read and address aliasing.
        set_cmd(1, 0, 0, 0, 32'hAABBCCDD, 32'h12345678, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0001;
        run_txn(0, LAT_MEM, 1'b1, 1'b0, "wr1");
        set_cmd(0, 1, 0, 0, 32'hAABBCCDD, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0010;
        run_txn(1, LAT_MEM, 1'b1, 1'b0, "rd1");
        check("rd1 memData", memData, 32'h12345678);
        set_cmd(1, 0, 0, 0, 32'h00000040, 32'h0BADF00D, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0100;
        run_txn(2, LAT_MEM, 1'b1, 1'b0, "wr40");
        set_cmd(0, 1, 0, 0, 32'h00000040, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b1000;
        run_txn(3, LAT_MEM, 1'b1, 1'b0, "rd40");
        check("rd40 memData", memData, 32'h0BADF00D);
        set_cmd(0, 1, 0, 0, 32'h000000DC, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0001;
        run_txn(0, LAT_MEM, 1'b1, 1'b0, "rdDC");
        check("rdDC alias memData", memData, 32'h12345678);

        // Register file path.
        set_cmd(0, 0, 1, 0, 32'h0, 32'hFACECAFE, 5'd0, 5'd0, 5'd10, 1'b0);
        bus_request = 4'b0010;
        run_txn(1, LAT_REG, 1'b1, 1'b0, "rdw10");
        set_cmd(0, 0, 0, 1, 32'h0, 32'h0, 5'd10, 5'd0, 5'd0, 1'b1);
        bus_request = 4'b0100;
        run_txn(2, LAT_REG, 1'b0, 1'b1, "rden sel1");
        check("rden sel1 Amux", AmuxBus, 32'hFACECAFE);
        check("rden sel1 Bmux", BmuxBus, 32'h0);
        set_cmd(0, 0, 0, 1, 32'h0, 32'hDCBA4321, 5'd10, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0100;
        run_txn(2, LAT_REG, 1'b0, 1'b1, "rden sel0");
        check("rden sel0 Amux", AmuxBus, 32'hFACECAFE);
        check("rden sel0 Bmux", BmuxBus, 32'hDCBA4321);
        set_cmd(0, 0, 1, 0, 32'h0, 32'h11111111, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0001;
        run_txn(0, LAT_REG, 1'b1, 1'b0, "rdw x0");
        set_cmd(0, 0, 0, 1, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0, 1'b1);
        bus_request = 4'b0001;
        run_txn(0, LAT_REG, 1'b0, 1'b1, "rden x0");
        check("rden x0 Amux", AmuxBus, 32'h0);
        check("rden x0 Bmux", BmuxBus, 32'hFACECAFE);

        // mem_read + rd_write: only the read executes.
        set_cmd(0, 1, 1, 0, 32'h00000040, 32'h77777777, 5'd0, 5'd0, 5'd10, 1'b0);
        bus_request = 4'b1000;
        run_txn(3, LAT_MEM, 1'b1, 1'b0, "multi");
        check("multi memData", memData, 32'h0BADF00D);
        set_cmd(0, 0, 0, 1, 32'h0, 32'h0, 5'd10, 5'd10, 5'd0, 1'b1);
        bus_request = 4'b1000;
        run_txn(3, LAT_REG, 1'b0, 1'b1, "multi rden");
        check("multi reg unchanged", AmuxBus, 32'hFACECAFE);

        // No strobe: no pulse, grant held until request drops, outputs hold.
        set_cmd(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0010;
        run_txn(1, LAT_REG, 1'b0, 1'b0, "nostrobe");
        check("nostrobe Amux hold", AmuxBus, 32'hFACECAFE);
        check("nostrobe memData hold", memData, 32'h0BADF00D);

        // Request dropped during MEM_WAIT: transaction still completes.
        set_cmd(0, 1, 0, 0, 32'hAABBCCDD, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus_request = 4'b0100;
        tick();
        check("drop grant", 32'(grant), 32'b0100);
        tick();
        bus_request = 4'b0000;
        tick();
        check("drop early", 32'(mem_ackBus), 32'd0);
        check("drop grant held", 32'(grant), 32'b0100);
        tick();
        check("drop ack", 32'(mem_ackBus), 32'd1);
        check("drop memData", memData, 32'h12345678);
        tick();
        check("drop grant clr", 32'(grant), 32'd0);
        check("drop ack clr", 32'(mem_ackBus), 32'd0);

        // Reset clears the register file and rr_ptr.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        set_cmd(0, 0, 0, 1, 32'h0, 32'h0, 5'd10, 5'd0, 5'd0, 1'b1);
        bus_request = 4'b1000;
        run_txn(3, LAT_REG, 1'b0, 1'b1, "rst regs");
        check("rst regs Amux", AmuxBus, 32'h0);

        // Round-robin with all four PEs requesting; rr_ptr wrapped to 0 after PE3.
        set_cmd(0, 0, 1, 0, 32'h0, 32'h5, 5'd0, 5'd0, 5'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus_request = 4'b1111;
            run_txn(i % N_PE, LAT_REG, 1'b1, 1'b0, $sformatf("arb%0d", i));
        end
        bus_request = '0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_bus_responder.md
# pe_bus_responder

Bus-side responder and arbiter for the PE shared bus: the far end of each PE's `bus_interface`. Arbitrates `bus_request` from N_PE processing elements round-robin and drives the one-hot `grant`. Executes the granted PE's transaction against a global data memory and a shared register file. Returns `memData`/`mem_ackBus` for memory operations and `AmuxBus`/`BmuxBus`/`data_ReadyBus` for register reads.

## Interface
- N_PE, 4: number of requesting PEs (2..8)
- MEM_AW, 8: global memory word-address width (depth 2^MEM_AW words of 32 bits)
- MEM_LAT, 2: wait cycles for a memory access (1..15)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- bus_request  in  N_PE  per-PE request, level, held until transaction done
- grant  out  N_PE  one-hot grant, registered
- mem_addressBus  in  32  byte address from granted PE
- result_outBus  in  32  write data / immediate
- rs1OutBus, rs2OutBus, rdOutBus  in  5 each  register indices
- reg_selectBus  in  1  1 = B operand from register rs2, 0 = B from result_outBus
- mem_readBus, mem_writeBus, rd_writeBus, read_enBus  in  1 each  command strobes
- memData  out  32  memory read data, valid while mem_ackBus=1
- mem_ackBus  out  1  one-cycle completion pulse for memory and rd-write ops
- AmuxBus, BmuxBus  out  32 each  operands, valid while data_ReadyBus=1
- data_ReadyBus  out  1  one-cycle completion pulse for register reads

## Operation
- **State machine:** IDLE, SAMPLE, MEM_WAIT, RESP, RELEASE.
- **IDLE:** if any request, pick the first requester at or after `rr_ptr` (wrapping), set `grant` to that bit, go to SAMPLE. With no request, stay in IDLE.
- **SAMPLE:** latch all bus command/data inputs. The command is decoded by priority mem_write > mem_read > rd_write > read_en, and only the winning strobe is executed.
  - Memory ops go to MEM_WAIT with counter = MEM_LAT.
  - rd_write/read_en are executed in this cycle and go to RESP.
  - No strobe: go to RELEASE with no pulse.
- **MEM_WAIT:** decrement the counter. At 1, perform the access and go to RESP.
  - Word index = mem_addressBus[MEM_AW+1:2]. Bits [1:0] are ignored; upper bits are ignored, so addresses wrap modulo the memory size.
  - A write stores result_outBus. A read loads memData.
- **Register file:** 32x32, x0 reads 0. A write to rd=0 is discarded but still acked.
  - read_en: AmuxBus = R[rs1]; BmuxBus = reg_selectBus ? R[rs2] : result_outBus.
- **RESP:** for exactly one cycle, assert mem_ackBus (mem read/write, rd_write) or data_ReadyBus (read_en). Go to RELEASE.
- **RELEASE:** hold `grant` until the granted PE's bus_request is low.
  - When the request is sampled low, clear `grant`, set `rr_ptr` = granted index + 1 mod N_PE, and go to IDLE.
- **Commit rule:** a transaction is committed at SAMPLE. Dropping bus_request afterward does not abort it; the pulse is still issued.
- Bus inputs are ignored outside SAMPLE.
- **Output holding:** memData/AmuxBus/BmuxBus hold their last value after the pulse.

## Timing
- **Reset (async, any state):** state=IDLE, grant=0, rr_ptr=0, mem_ackBus=0, data_ReadyBus=0, memData=0, AmuxBus=0, BmuxBus=0, register file cleared. Memory contents are not reset.
- **Reset mid-transaction:** the pending write is dropped and no pulse is issued.
- Edges are numbered from E0, the edge where the request is first sampled high in IDLE.
  - grant is high after E0.
  - Command is latched at E1.
  - Register op: pulse high E2..E3.
  - Memory op: pulse high E(1+MEM_LAT)..E(2+MEM_LAT). With MEM_LAT=2 this is E3..E4.
- The earliest grant drop is one edge after RESP, if the request is already low.
- Back-to-back: at least one IDLE cycle between grants, so each PE's minimum turnaround is RESP+2 cycles.
- **Fairness:** simultaneous requests are served in rotating order. No PE waits more than N_PE-1 transactions.
- **Outputs:** all outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** reset=0 mid-MEM_WAIT of a write to 0x10 -> all outputs 0, state IDLE, and a later read of 0x10 does not return the dropped data.
- **Memory write/read (PE0, MEM_LAT=2):** write 0x12345678 to 0xAABBCCDD, release, then read 0xAABBCCDD -> mem_ackBus pulses E3 for each. On the read, memData=0x12345678. Address 0x000000DC aliases to the same word.
- **Register path:** rd_write rd=10, data 0xFACECAFE -> ack at E2. Then read_en rs1=10, rs2=0, reg_select=1 -> AmuxBus=0xFACECAFE, BmuxBus=0, data_ReadyBus one cycle. With reg_select=0 and result_outBus=0xDCBA4321 -> BmuxBus=0xDCBA4321.
- **Arbitration:** all 4 PEs request continuously -> grant order 0,1,2,3,0. Never two grant bits high at once.
- **Multi-strobe and no-strobe:** mem_read+rd_write together -> only the read is executed and the register is unchanged. No strobe -> no pulse, and grant releases when the request drops.
- **Early request drop:** request dropped in MEM_WAIT -> ack still pulses, then grant clears next edge.
